ibuf_stream_writer: RTL and testbench
=====================================

// Module: ibuf_stream_writer
// PURPOSE
//  Transmit side of the layer-to-layer input-buffer interface. Accepts per-channel result
//  vectors from the upstream layer's function unit, buffers them in a small FIFO, and writes
//  them pixel-by-pixel into the downstream layer's per-channel window ibuf.
//  Tracks the raster position of each written pixel. Pulses the downstream start only when a
//  full kernel_dim x kernel_dim window is resident. Obeys the downstream busy flag.
// PARAMETERS
//  channels      5   channel count; lanes on both sides
//  img_width     28  downstream (square) image width in pixels
//  kernel_dim    5   downstream kernel dim K (KxK window)
//  datatype_size 8   bits per channel value
//  fifo_depth    4   staging FIFO entries (>=2)
// PORTS
//  clk             in   1                            clock
//  rst             in   1                            async reset, ACTIVE-LOW
//  i_valid         in   1                            upstream vector valid
//  o_ready         out  1                            FIFO can accept (= !full)
//  i_data          in   [datatype_size-1:0] x chan   upstream channel vector
//  o_ibuf_we       out  1 x channels                 downstream ibuf write enables (all lanes equal)
//  o_ibuf_wr_data  out  [datatype_size-1:0] x chan   downstream ibuf write data
//  o_start         out  1                            1-cycle pulse: window ready, start downstream
//  i_next_busy     in   1                            downstream busy computing
//  o_frame_done    out  1                            1-cycle pulse after last window of frame started
// BEHAVIOUR
//  Clock/reset: one clock. rst is asynchronous, active-low.
//  Reset: all outputs 0. FIFO empty. row=col=0. State=STREAM.
//  Reset mid-frame discards FIFO content and position.
//  Push: on edge with i_valid & o_ready. o_ready is combinational from FIFO count, not from i_valid.
//  Pop/write:
//   - In STREAM, when FIFO non-empty and i_next_busy=0: pop head.
//   - Next cycle o_ibuf_we=1 and o_ibuf_wr_data=head (outputs registered).
//   - Minimum latency: accepted at edge t -> o_ibuf_we high in cycle after edge t+1.
//   - Push and pop in the same cycle are allowed.
//   - Full: push refused, pop proceeds.
//   - Empty: no write, no bypass.
//  Position: each write advances col; col wraps img_width-1 -> 0 and row++;
//   row wraps img_width-1 -> 0. Counter widths are $clog2(img_width).
//  Window valid: written pixel has row>=K-1 and col>=K-1. Windows that straddle a row wrap never fire.
//  FSM:
//   STREAM -> FIRE when a window-valid pixel is written.
//   FIRE: no writes. Wait until i_next_busy=0, then pulse o_start for 1 cycle -> GUARD.
//   GUARD: exactly 1 cycle, no writes; absorbs downstream busy-rise lag -> STREAM.
//    If the fired pixel was (W-1,W-1), also pulse o_frame_done in this cycle.
//  i_next_busy=1 in STREAM stalls pops. The ibuf shifts on every write, so no write is issued
//   while downstream is busy.
//  Per frame: exactly (W-K+1)^2 o_start pulses and exactly W^2 writes.
//  The next frame streams immediately after GUARD.
//  Degenerate K=1: every pixel fires. K>W is illegal; elaboration $error.
// STRUCTURE
//  Package layer_pkg:
//   - typedef enum {STREAM, FIRE, GUARD} wr_state_t
//   - localparam helper for position width ($clog2)
//   - typedef for channel vector packing
//  Sub-module vec_fifo:
//   - parameters width=channels*datatype_size, depth=fifo_depth
//   - ports: push/pop/full/empty/count, registered storage, async active-low reset
//  Top: FSM, row/col counters, output registers.
// TESTING
//  T1 reset: hold rst=0 with random inputs -> all outputs 0, o_ready=1.
//   Release mid-frame -> position restarts at (0,0).
//  T2 W=6,K=3, stream 36 vectors, busy=0:
//   - 36 writes in raster order; o_start exactly 16 times, first after pixel (2,2)
//   - no start after cols 0-1 of any row
//   - o_frame_done once, after last start
//  T3 backpressure: push 10 vectors in consecutive cycles with pops stalled by busy=1 ->
//   o_ready falls after 4 accepts; no data lost or reordered after busy drops.
//  T4 busy held 20 cycles during FIRE -> o_start delayed until busy=0;
//   zero writes during busy, FIRE and GUARD.
//  T5 K=1, W=4: 16 writes, 16 starts, each separated by the GUARD cycle.
//  T6 two back-to-back frames with random i_valid gaps: second frame positions restart at 0;
//   32 starts total for W=6,K=3.

Source files
------------

// File: rtl/ibuf_stream_writer_pkg.sv
// Shared types and helpers for the layer-to-layer input-buffer stream writer.
package layer_pkg;

  typedef enum logic [1:0] {
    STREAM,
    FIRE,
    GUARD
  } wr_state_t;

  localparam int unsigned DEF_CHANNELS      = 5;
  localparam int unsigned DEF_DATATYPE_SIZE = 8;

  typedef logic [DEF_CHANNELS-1:0][DEF_DATATYPE_SIZE-1:0] chan_vec_t;

  // Raster counter width; a 1-pixel image still needs one bit of storage.
  function automatic int unsigned pos_width(input int unsigned img_width);
    return (img_width > 1) ? $clog2(img_width) : 1;
  endfunction

endpackage

// File: rtl/ibuf_stream_writer_if.sv
// Upstream vector handshake plus downstream ibuf write/start signals of the stream writer.
interface ibuf_stream_writer_if #(
  parameter int unsigned channels      = 5,
  parameter int unsigned datatype_size = 8
);

  logic                                   i_valid;
  logic                                   o_ready;
  logic [channels-1:0][datatype_size-1:0] i_data;
  logic [channels-1:0]                    o_ibuf_we;
  logic [channels-1:0][datatype_size-1:0] o_ibuf_wr_data;
  logic                                   o_start;
  logic                                   i_next_busy;
  logic                                   o_frame_done;

  modport master (
    input  i_valid, i_data, i_next_busy,
    output o_ready, o_ibuf_we, o_ibuf_wr_data, o_start, o_frame_done
  );

  modport slave (
    output i_valid, i_data, i_next_busy,
    input  o_ready, o_ibuf_we, o_ibuf_wr_data, o_start, o_frame_done
  );

endinterface

// File: rtl/ibuf_stream_writer_vec_fifo.sv
// Small circular staging FIFO for channel vectors; head is visible combinationally.
module vec_fifo #(
  parameter int unsigned width = 40,
  parameter int unsigned depth = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic                         pop,
  input  logic [width-1:0]             din,
  output logic [width-1:0]             dout,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(depth+1)-1:0]   count
);

  localparam int unsigned    PTR_W    = $clog2(depth);
  localparam int unsigned    CNT_W    = $clog2(depth + 1);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(depth - 1);

  logic [width-1:0] mem_q [depth];
  logic [width-1:0] mem_d [depth];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign full    = (count_q == CNT_W'(depth));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign dout    = mem_q[rd_ptr_q];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = din;
      wr_ptr_d        = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + 1'b1;
    end
    if (do_pop) begin
      rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + 1'b1;
    end
    unique case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/ibuf_stream_writer.sv
// Streams buffered channel vectors into the downstream window ibuf and starts the
// downstream layer each time a full KxK window is resident.
module ibuf_stream_writer
  import layer_pkg::*;
#(
  parameter int unsigned channels      = 5,
  parameter int unsigned img_width     = 28,
  parameter int unsigned kernel_dim    = 5,
  parameter int unsigned datatype_size = 8,
  parameter int unsigned fifo_depth    = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  ibuf_stream_writer_if.master bus
);

  localparam int unsigned   VEC_W     = channels * datatype_size;
  localparam int unsigned   PW        = pos_width(img_width);
  localparam int unsigned   CNT_W     = $clog2(fifo_depth + 1);
  localparam logic [PW-1:0] POS_LAST  = PW'(img_width - 1);
  localparam logic [PW-1:0] WIN_FIRST = PW'(kernel_dim - 1);

  if (kernel_dim == 0 || kernel_dim > img_width) begin : g_bad_kernel
    $error("ibuf_stream_writer: kernel_dim must be in 1..img_width");
  end
  if (fifo_depth < 2) begin : g_bad_depth
    $error("ibuf_stream_writer: fifo_depth must be at least 2");
  end

  wr_state_t        state_q, state_d;
  logic [PW-1:0]    row_q, row_d;
  logic [PW-1:0]    col_q, col_d;
  logic             we_q, we_d;
  logic [VEC_W-1:0] wr_data_q, wr_data_d;
  logic             last_fired_q, last_fired_d;

  logic             fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [VEC_W-1:0] fifo_head;
  logic [CNT_W-1:0] unused_fifo_count;
  logic             win_valid, at_frame_end;

  // Pops only in STREAM: every ibuf write shifts the window, so none may land while
  // the downstream layer is busy or a start is being issued.
  assign fifo_push = bus.i_valid && !fifo_full;
  assign fifo_pop  = (state_q == STREAM) && !fifo_empty && !bus.i_next_busy;

  vec_fifo #(
    .width (VEC_W),
    .depth (fifo_depth)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   (bus.i_data),
    .dout  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (unused_fifo_count)
  );

  if (kernel_dim == 1) begin : g_win_k1
    assign win_valid = 1'b1;
  end else begin : g_win_kn
    assign win_valid = (row_q >= WIN_FIRST) && (col_q >= WIN_FIRST);
  end

  assign at_frame_end = (row_q == POS_LAST) && (col_q == POS_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= STREAM;
      row_q        <= '0;
      col_q        <= '0;
      we_q         <= 1'b0;
      wr_data_q    <= '0;
      last_fired_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      row_q        <= row_d;
      col_q        <= col_d;
      we_q         <= we_d;
      wr_data_q    <= wr_data_d;
      last_fired_q <= last_fired_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      STREAM:  if (fifo_pop && win_valid) state_d = FIRE;
      FIRE:    if (!bus.i_next_busy) state_d = GUARD;
      GUARD:   state_d = STREAM;
      default: state_d = STREAM;
    endcase
  end

  always_comb begin
    row_d        = row_q;
    col_d        = col_q;
    we_d         = fifo_pop;
    wr_data_d    = wr_data_q;
    last_fired_d = last_fired_q;
    if (fifo_pop) begin
      wr_data_d = fifo_head;
      if (win_valid) last_fired_d = at_frame_end;
      if (col_q == POS_LAST) begin
        col_d = '0;
        row_d = (row_q == POS_LAST) ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end
  end

  always_comb begin
    bus.o_ready        = !fifo_full;
    bus.o_ibuf_we      = {channels{we_q}};
    bus.o_ibuf_wr_data = wr_data_q;
    bus.o_start        = (state_q == FIRE) && !bus.i_next_busy;
    bus.o_frame_done   = (state_q == GUARD) && last_fired_q;
  end

endmodule

// File: tb/tb_ibuf_stream_writer.sv
// Directed bench for ibuf_stream_writer: A is W=6,K=3; B is W=4,K=1.
module tb_ibuf_stream_writer;

  localparam int unsigned CH = 5;
  localparam int unsigned DS = 8;
  typedef logic [CH*DS-1:0] vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ibuf_stream_writer_if #(.channels(CH), .datatype_size(DS)) bus_a ();
  ibuf_stream_writer_if #(.channels(CH), .datatype_size(DS)) bus_b ();

  ibuf_stream_writer #(
    .channels(CH), .img_width(6), .kernel_dim(3), .datatype_size(DS), .fifo_depth(4)
  ) dut_a (.clk(clk), .rst(rst), .bus(bus_a));

  ibuf_stream_writer #(
    .channels(CH), .img_width(4), .kernel_dim(1), .datatype_size(DS), .fifo_depth(4)
  ) dut_b (.clk(clk), .rst(rst), .bus(bus_b));

  int   vectors = 0;
  int   miscompares = 0;
  vec_t sb0[$];
  vec_t sb1[$];
  int   wm[2] = '{6, 4};
  int   km[2] = '{3, 1};
  int   row_m[2], col_m[2], writes[2], starts[2], frames[2], fd_seen[2];
  int   accepts[2], to_send[2], fw[2];
  bit   pending[2], pend_last[2], exp_fd[2], prev_busy[2], prev_start[2];
  bit   first_in_frame[2], gaps[2], acc[2];
  bit   mon_en = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic vec_t rand_vec();
    return {$urandom(), 8'($urandom())};
  endfunction

  task automatic reset_model();
    for (int d = 0; d < 2; d++) begin
      row_m[d] = 0; col_m[d] = 0; writes[d] = 0; starts[d] = 0; frames[d] = 0;
      fd_seen[d] = 0; accepts[d] = 0; to_send[d] = 0; fw[d] = 0;
      pending[d] = 0; pend_last[d] = 0; exp_fd[d] = 0; prev_busy[d] = 0;
      prev_start[d] = 0; first_in_frame[d] = 0; gaps[d] = 0; acc[d] = 0;
    end
    sb0.delete();
    sb1.delete();
  endtask

  task automatic mon(input int d, input logic valid, input logic ready, input logic busy,
                     input logic start, input logic fd, input logic [CH-1:0] we,
                     input vec_t wd, input vec_t id);
    vec_t exp;
    int   sz;
    if (we !== '0) begin
      chk("we_lanes", we, {CH{1'b1}});
      chk("write_after_busy", prev_busy[d], 0);
      chk("write_in_guard", prev_start[d], 0);
      chk("write_in_fire", pending[d], 0);
      sz = (d == 0) ? sb0.size() : sb1.size();
      chk("write_has_source", (sz != 0), 1);
      if (sz != 0) begin
        exp = (d == 0) ? sb0.pop_front() : sb1.pop_front();
        chk("wr_data", wd, exp);
      end
      if (row_m[d] == 0 && col_m[d] == 0) begin
        fw[d] = 0;
        first_in_frame[d] = 1;
      end
      if (row_m[d] >= km[d] - 1 && col_m[d] >= km[d] - 1) begin
        pending[d]   = 1;
        pend_last[d] = (row_m[d] == wm[d] - 1) && (col_m[d] == wm[d] - 1);
      end
      if (col_m[d] == wm[d] - 1) begin
        col_m[d] = 0;
        row_m[d] = (row_m[d] == wm[d] - 1) ? 0 : row_m[d] + 1;
      end else begin
        col_m[d]++;
      end
      writes[d]++;
      fw[d]++;
    end
    acc[d] = valid && ready;
    if (acc[d]) begin
      if (d == 0) sb0.push_back(id); else sb1.push_back(id);
      accepts[d]++;
    end
    chk("frame_done", fd, exp_fd[d]);
    if (fd === 1'b1) fd_seen[d]++;
    exp_fd[d] = 0;
    if (start === 1'b1) begin
      chk("start_window", pending[d], 1);
      chk("start_busy", busy, 0);
      chk("start_b2b", prev_start[d], 0);
      if (first_in_frame[d]) begin
        chk("first_start_pos", fw[d], (km[d] - 1) * wm[d] + km[d]);
        first_in_frame[d] = 0;
      end
      if (pending[d] && pend_last[d]) begin
        exp_fd[d] = 1;
        frames[d]++;
      end
      starts[d]++;
      pending[d] = 0;
    end
    prev_busy[d]  = busy;
    prev_start[d] = start;
  endtask

  task automatic feed(input int d);
    logic v;
    if (acc[d]) begin
      to_send[d]--;
      if (d == 0) bus_a.i_data = rand_vec(); else bus_b.i_data = rand_vec();
    end
    acc[d] = 0;
    v = (to_send[d] > 0) && (!gaps[d] || $urandom_range(0, 3) != 0);
    if (d == 0) bus_a.i_valid = v; else bus_b.i_valid = v;
  endtask

  task automatic cyc();
    @(negedge clk);
    if (mon_en) begin
      mon(0, bus_a.i_valid, bus_a.o_ready, bus_a.i_next_busy, bus_a.o_start,
          bus_a.o_frame_done, bus_a.o_ibuf_we, bus_a.o_ibuf_wr_data, bus_a.i_data);
      mon(1, bus_b.i_valid, bus_b.o_ready, bus_b.i_next_busy, bus_b.o_start,
          bus_b.o_frame_done, bus_b.o_ibuf_we, bus_b.o_ibuf_wr_data, bus_b.i_data);
    end
    @(posedge clk);
    #1;
    if (mon_en) begin
      feed(0);
      feed(1);
    end
  endtask

  task automatic add_feed(input int d, input int n);
    to_send[d] += n;
    if (d == 0) bus_a.i_valid = 1'b1; else bus_b.i_valid = 1'b1;
  endtask

  task automatic run_until(input int ta, input int tb, input int budget, input string tag);
    int n = 0;
    while ((writes[0] < ta || writes[1] < tb || pending[0] || pending[1]) && n < budget) begin
      cyc();
      n++;
    end
    chk(tag, (n < budget), 1);
    repeat (4) cyc();
  endtask

  task automatic rst_chk(input string tag, input logic ready, input logic [CH-1:0] we,
                         input vec_t wd, input logic st, input logic fd);
    chk({tag, "_ready"}, ready, 1);
    chk({tag, "_we"}, we, 0);
    chk({tag, "_wdata"}, wd, 0);
    chk({tag, "_start"}, st, 0);
    chk({tag, "_fdone"}, fd, 0);
  endtask

  task automatic drive_zero();
    bus_a.i_valid = 0; bus_a.i_next_busy = 0; bus_a.i_data = '0;
    bus_b.i_valid = 0; bus_b.i_next_busy = 0; bus_b.i_data = '0;
  endtask

  int s0, f0, a0;

  initial begin
    drive_zero();
    reset_model();
    #2 rst = 1'b0;
    // T1: random inputs under reset
    repeat (6) begin
      @(posedge clk); #1;
      bus_a.i_valid = 1'($urandom()); bus_a.i_next_busy = 1'($urandom()); bus_a.i_data = rand_vec();
      bus_b.i_valid = 1'($urandom()); bus_b.i_next_busy = 1'($urandom()); bus_b.i_data = rand_vec();
      @(negedge clk);
      rst_chk("rst_a", bus_a.o_ready, bus_a.o_ibuf_we, bus_a.o_ibuf_wr_data, bus_a.o_start, bus_a.o_frame_done);
      rst_chk("rst_b", bus_b.o_ready, bus_b.o_ibuf_we, bus_b.o_ibuf_wr_data, bus_b.o_start, bus_b.o_frame_done);
    end
    @(posedge clk); #1;
    drive_zero();
    rst = 1'b1;
    mon_en = 1'b1;
    bus_a.i_data = rand_vec(); bus_b.i_data = rand_vec();
    add_feed(0, 10);
    add_feed(1, 3);
    repeat (12) cyc();
    // mid-frame reset
    rst = 1'b0;
    mon_en = 1'b0;
    @(negedge clk);
    rst_chk("midrst_a", bus_a.o_ready, bus_a.o_ibuf_we, bus_a.o_ibuf_wr_data, bus_a.o_start, bus_a.o_frame_done);
    rst_chk("midrst_b", bus_b.o_ready, bus_b.o_ibuf_we, bus_b.o_ibuf_wr_data, bus_b.o_start, bus_b.o_frame_done);
    @(posedge clk); #1;
    drive_zero();
    reset_model();
    rst = 1'b1;
    mon_en = 1'b1;

    // T2 (A) and T5 (B): one full frame each, no backpressure
    bus_a.i_data = rand_vec(); bus_b.i_data = rand_vec();
    add_feed(0, 36);
    add_feed(1, 16);
    run_until(36, 16, 400, "t2_timeout");
    chk("t2_writes", writes[0], 36);
    chk("t2_starts", starts[0], 16);
    chk("t2_frames", fd_seen[0], 1);
    chk("t5_writes", writes[1], 16);
    chk("t5_starts", starts[1], 16);
    chk("t5_frames", fd_seen[1], 1);

    // T3: pops stalled, FIFO fills
    bus_a.i_next_busy = 1'b1;
    a0 = accepts[0];
    add_feed(0, 10);
    repeat (12) cyc();
    chk("t3_accepts", accepts[0] - a0, 4);
    chk("t3_ready", bus_a.o_ready, 0);
    chk("t3_no_write", writes[0], 36);
    bus_a.i_next_busy = 1'b0;
    run_until(46, 16, 200, "t3_timeout");
    chk("t3_writes", writes[0], 46);
    chk("t3_drained", sb0.size(), 0);

    // T4: busy held while the window at pixel (2,2) waits to fire
    add_feed(0, 4);
    run_until(50, 16, 200, "t4a_timeout");
    bus_a.i_next_busy = 1'b1;
    add_feed(0, 6);
    repeat (3) cyc();
    s0 = starts[0];
    bus_a.i_next_busy = 1'b0;
    cyc();
    bus_a.i_next_busy = 1'b1;
    repeat (20) cyc();
    chk("t4_pending", pending[0], 1);
    chk("t4_no_start", starts[0], s0);
    chk("t4_one_write", writes[0], 51);
    bus_a.i_next_busy = 1'b0;
    cyc();
    chk("t4_start", starts[0], s0 + 1);
    add_feed(0, 16);
    run_until(72, 16, 400, "t4b_timeout");
    chk("t4_frame_starts", starts[0], 32);
    chk("t4_frames", fd_seen[0], 2);

    // T6: two back-to-back frames with random valid gaps
    s0 = starts[0];
    f0 = fd_seen[0];
    gaps[0] = 1;
    add_feed(0, 72);
    run_until(144, 16, 2000, "t6_timeout");
    chk("t6_writes", writes[0], 144);
    chk("t6_starts", starts[0] - s0, 32);
    chk("t6_frames", fd_seen[0] - f0, 2);
    chk("t6_model_frames", frames[0], 4);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
